vga_sprite_ctrl: RTL and testbench
==================================

Name: vga_sprite_ctrl

Overview:
- Pixel-generation stage directly downstream of the VGA sync generator.
- Consumes the 11-bit horizontal/vertical counters (c1, c2) and drives the pixel ROM address.
- Produces 3-bit rgb with a fixed 2-clock latency, so the top level's existing 2-stage hsync/vsync bypass stays aligned.
- Renders one 8x16 monochrome sprite that bounces inside the active area and cycles through animation frames stored in ROM.

Parameters:
- H_ACT_START, 216, c1 value of first active pixel
- V_ACT_START, 27, c2 value of first active line
- H_ACT, 800, active pixels per line
- V_ACT, 600, active lines per frame
- SPR_W, 8, sprite width (fixed by 8-bit ROM word)
- SPR_H, 16, sprite height (rows per animation frame)
- NUM_FRAMES, 4, animation frames in ROM (1..128)
- ANIM_DIV, 8, video frames per animation step (1..255)
- X0, 0, reset sprite x
- Y0, 0, reset sprite y
- FG_COLOR, 3'b111, colour for set sprite bits
- BG_COLOR, 3'b001, colour for active non-sprite pixels

Ports:
- clk  in  1  system pixel clock
- rst_n  in  1  asynchronous active-low reset
- c1  in  11  horizontal counter from sync generator
- c2  in  11  vertical counter from sync generator
- move_en  in  1  when 1, sprite position and animation advance at each frame tick
- rom_addr  out  11  {frame_idx[6:0], row[3:0]}, registered
- rom_data  in  8  ROM word, valid 1 clk after rom_addr (synchronous ROM)
- rgb  out  3  pixel colour, valid 2 clks after the c1/c2 it belongs to
- frame_tick  out  1  1-clk pulse at start of vertical blank, registered

Behaviour:
- Reset: clk and rst_n are one clock domain; reset is asynchronous and active-low.
  - Reset values: rom_addr=0, rgb=0, frame_tick=0, x=X0, y=Y0, dx=+1, dy=+1, frame_idx=0, anim_cnt=0, all pipeline flags 0.
  - Reset asserted mid-frame forces rgb=0 immediately. Rendering resumes on the next counters after release; no frame realignment is needed.
- Stage 0 (combinational from c1, c2):
  - px = c1 - H_ACT_START; py = c2 - V_ACT_START.
  - act = (H_ACT_START <= c1 < H_ACT_START+H_ACT) and (V_ACT_START <= c2 < V_ACT_START+V_ACT).
  - hit = act and (x <= px < x+SPR_W) and (y <= py < y+SPR_H).
- Edge k+1 (stage 1): register rom_addr <= {frame_idx, (py-y)[3:0]} when hit, else hold the previous value. Register act1, hit1 and col1=(px-x)[2:0].
- Edge k+2 (stage 2): register act2, hit2 and col2. The ROM presents rom_data for the stage-1 address.
- rgb during cycle after edge k+2 (combinational from the stage-2 flags and rom_data):
  - 0 when !act2.
  - FG_COLOR when hit2 and rom_data[7-col2].
  - BG_COLOR otherwise.
  - Column 0 = MSB. Total latency is exactly 2 clk edges.
- Frame tick:
  - Asserted for one clk when c1==0 and c2==V_ACT_START+V_ACT, registered one clk after that condition.
  - Position and animation registers update on the same edge that frame_tick rises. This is inside vertical blank, so there is no tearing.
- Motion, only when move_en=1 at the tick. XMAX = H_ACT-SPR_W, YMAX = V_ACT-SPR_H.
  - Moving right with x==XMAX: dx becomes -1 and x decrements.
  - Moving left with x==0: dx becomes +1 and x increments.
  - Otherwise x <= x+dx.
  - y follows the same rules with YMAX.
  - x and y never leave [0, XMAX] and [0, YMAX].
- Animation, only when move_en=1 at the tick:
  - anim_cnt increments; when it reaches ANIM_DIV-1 it clears and frame_idx advances.
  - frame_idx wraps NUM_FRAMES-1 -> 0.
- move_en=0: tick still pulses; x, y, dx, dy, anim_cnt and frame_idx hold.
- Counter values outside the configured timing (e.g. c1 beyond line total) are simply treated as not active.

Test Plan:
- Reset held, then released at c1=0, c2=0 -> rgb=0, rom_addr=0, frame_tick=0 until the first active pixel. First active pixel (c1=216, c2=27), X0=Y0=0, ROM row 0 = 8'h80 -> rgb=3'b111 exactly 2 clks later. Next pixel -> 3'b001.
- Sprite at x=100, y=50, ROM row 3 = 8'h01 -> c1=216+107, c2=27+53 gives rgb=3'b111; c1=216+108 gives 3'b001; rom_addr={frame_idx, 4'd3}.
- Horizontal blanking/front porch counters (c1=100) -> rgb=0 regardless of rom_data.
- Bounce, forcing x=792 with dx=+1 and move_en=1 -> after tick x=791 and dx=-1. From x=0 with dx=-1 -> x=1 and dx=+1. Same checks for y at 584 and 0.
- Animation with ANIM_DIV=8, NUM_FRAMES=4 -> frame_idx increments every 8 ticks and goes 3 -> 0 after 32 ticks. With move_en=0 for 5 ticks -> x, y and frame_idx unchanged; frame_tick still pulses 5 times.
- Reset asserted mid-active-line -> rgb=0 asynchronously. After release, x=X0, y=Y0, frame_idx=0, and correct output resumes within 2 clks of valid counters.

Source files
------------

// File: rtl/vga_sprite_ctrl_if.sv
// Signal bundle between the sync generator / pixel ROM and the sprite renderer.
// The slave side is the renderer; the master side drives counters and ROM data.
interface vga_sprite_ctrl_if;
  logic [10:0] c1;
  logic [10:0] c2;
  logic        move_en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [2:0]  rgb;
  logic        frame_tick;

  modport slave (
    input  c1,
    input  c2,
    input  move_en,
    input  rom_data,
    output rom_addr,
    output rgb,
    output frame_tick
  );

  modport master (
    output c1,
    output c2,
    output move_en,
    output rom_data,
    input  rom_addr,
    input  rgb,
    input  frame_tick
  );
endinterface

// File: rtl/vga_sprite_ctrl.sv
// Bouncing, animated 8x16 monochrome sprite renderer with a fixed 2-clock pixel latency.
// Position and animation state update once per frame, inside vertical blank.
module vga_sprite_ctrl #(
  parameter int unsigned H_ACT_START = 216,
  parameter int unsigned V_ACT_START = 27,
  parameter int unsigned H_ACT       = 800,
  parameter int unsigned V_ACT       = 600,
  parameter int unsigned SPR_W       = 8,
  parameter int unsigned SPR_H       = 16,
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned X0          = 0,
  parameter int unsigned Y0          = 0,
  parameter logic [2:0]  FG_COLOR    = 3'b111,
  parameter logic [2:0]  BG_COLOR    = 3'b001
) (
  input logic               clk,
  input logic               rst_n,
  vga_sprite_ctrl_if.slave  bus
);

  localparam logic [10:0] HStart    = 11'(H_ACT_START);
  localparam logic [10:0] HEnd      = 11'(H_ACT_START + H_ACT);
  localparam logic [10:0] VStart    = 11'(V_ACT_START);
  localparam logic [10:0] VEnd      = 11'(V_ACT_START + V_ACT);
  localparam logic [10:0] SprW      = 11'(SPR_W);
  localparam logic [10:0] SprH      = 11'(SPR_H);
  localparam logic [10:0] XMax      = 11'(H_ACT - SPR_W);
  localparam logic [10:0] YMax      = 11'(V_ACT - SPR_H);
  localparam logic [6:0]  FrameLast = 7'(NUM_FRAMES - 1);
  localparam logic [7:0]  AnimLast  = 8'(ANIM_DIV - 1);

  // Sprite state; dx/dy are direction flags, 1 = +1, 0 = -1.
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [6:0]  frame_idx_q, frame_idx_d;
  logic [7:0]  anim_cnt_q, anim_cnt_d;

  // Pixel pipeline
  logic [10:0] rom_addr_q;
  logic        act1_q, hit1_q, act2_q, hit2_q;
  logic [2:0]  col1_q, col2_q;
  logic        tick_q;

  // Stage 0
  logic [10:0] px, py;
  logic        act, hit, tick_cond;
  logic [3:0]  row;
  logic [2:0]  col;

  assign px  = bus.c1 - HStart;
  assign py  = bus.c2 - VStart;
  assign act = (bus.c1 >= HStart) && (bus.c1 < HEnd) && (bus.c2 >= VStart) && (bus.c2 < VEnd);
  assign hit = act && (px >= x_q) && (px < x_q + SprW) && (py >= y_q) && (py < y_q + SprH);

  // Only the low bits of the offsets matter, so subtract the low bits directly.
  assign row = py[3:0] - y_q[3:0];
  assign col = px[2:0] - x_q[2:0];

  assign tick_cond = (bus.c1 == 11'd0) && (bus.c2 == VEnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      act1_q     <= 1'b0;
      hit1_q     <= 1'b0;
      col1_q     <= '0;
      act2_q     <= 1'b0;
      hit2_q     <= 1'b0;
      col2_q     <= '0;
      tick_q     <= 1'b0;
    end else begin
      if (hit) begin
        rom_addr_q <= {frame_idx_q, row};
      end
      act1_q <= act;
      hit1_q <= hit;
      col1_q <= col;
      act2_q <= act1_q;
      hit2_q <= hit1_q;
      col2_q <= col1_q;
      tick_q <= tick_cond;
    end
  end

  // Motion and animation advance on the same edge that raises frame_tick.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    frame_idx_d = frame_idx_q;
    anim_cnt_d  = anim_cnt_q;
    if (tick_cond && bus.move_en) begin
      if (dx_q) begin
        if (x_q == XMax) begin
          dx_d = 1'b0;
          x_d  = x_q - 11'd1;
        end else begin
          x_d  = x_q + 11'd1;
        end
      end else begin
        if (x_q == 11'd0) begin
          dx_d = 1'b1;
          x_d  = x_q + 11'd1;
        end else begin
          x_d  = x_q - 11'd1;
        end
      end

      if (dy_q) begin
        if (y_q == YMax) begin
          dy_d = 1'b0;
          y_d  = y_q - 11'd1;
        end else begin
          y_d  = y_q + 11'd1;
        end
      end else begin
        if (y_q == 11'd0) begin
          dy_d = 1'b1;
          y_d  = y_q + 11'd1;
        end else begin
          y_d  = y_q - 11'd1;
        end
      end

      if (anim_cnt_q == AnimLast) begin
        anim_cnt_d  = '0;
        frame_idx_d = (frame_idx_q == FrameLast) ? 7'd0 : frame_idx_q + 7'd1;
      end else begin
        anim_cnt_d  = anim_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= 11'(X0);
      y_q         <= 11'(Y0);
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      frame_idx_q <= '0;
      anim_cnt_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      frame_idx_q <= frame_idx_d;
      anim_cnt_q  <= anim_cnt_d;
    end
  end

  // act2 clears asynchronously, so reset blanks the output at once.
  always_comb begin
    bus.rgb = BG_COLOR;
    if (!act2_q) begin
      bus.rgb = 3'b000;
    end else if (hit2_q && bus.rom_data[3'd7 - col2_q]) begin
      bus.rgb = FG_COLOR;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Directed bench: two renderers (reset position 0,0 and 100,50) fed by the same counters,
// each with its own synchronous ROM model.
module tb_vga_sprite_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses  = 0;

  logic [7:0] mem [0:2047];

  vga_sprite_ctrl_if ifa ();
  vga_sprite_ctrl_if ifb ();

  vga_sprite_ctrl u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  vga_sprite_ctrl #(
    .X0 (100),
    .Y0 (50)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifa.rom_data <= mem[ifa.rom_addr];
    ifb.rom_data <= mem[ifb.rom_addr];
  end

  always @(negedge clk) begin
    if (ifa.frame_tick) pulses++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cnt(input int h, input int v);
    ifa.c1 = 11'(h);
    ifa.c2 = 11'(v);
    ifb.c1 = 11'(h);
    ifb.c2 = 11'(v);
  endtask

  task automatic set_move(input logic m);
    ifa.move_en = m;
    ifb.move_en = m;
  endtask

  // Present one pixel at a negedge and wait two clock edges for its colour.
  task automatic pixel(input int h, input int v);
    @(negedge clk);
    set_cnt(h, v);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_cnt(0, 627);
      @(negedge clk);
      set_cnt(1, 627);
    end
    @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int ex, input int exd, input int ey,
                           input int eyd);
    check({tag, " x"},  32'(u_a.x_q),  32'(ex));
    check({tag, " dx"}, 32'(u_a.dx_q), 32'(exd));
    check({tag, " y"},  32'(u_a.y_q),  32'(ey));
    check({tag, " dy"}, 32'(u_a.dy_q), 32'(eyd));
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin
      if (a[3:0] == 4'd0)      mem[a] = 8'h80;
      else if (a[3:0] == 4'd3) mem[a] = 8'h01;
      else                     mem[a] = 8'h3C;
    end
    rst_n = 1'b0;
    set_move(1'b1);
    set_cnt(0, 0);
    repeat (3) @(negedge clk);
    check("rst rgb", 32'(ifa.rgb), 0);
    check("rst rom_addr", 32'(ifa.rom_addr), 0);
    check("rst tick", 32'(ifa.frame_tick), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle rgb", 32'(ifa.rgb), 0);
    check("idle rom_addr", 32'(ifa.rom_addr), 0);
    check("idle tick", 32'(ifa.frame_tick), 0);

    // First active pixel: must appear exactly on the second edge.
    @(negedge clk);
    set_cnt(216, 27);
    @(posedge clk);
    #1;
    check("lat 1clk rgb", 32'(ifa.rgb), 0);
    check("first rom_addr", 32'(ifa.rom_addr), 0);
    @(posedge clk);
    #1;
    check("first px fg", 32'(ifa.rgb), 7);
    pixel(217, 27);
    check("second px bg", 32'(ifa.rgb), 1);

    // Sprite at 100,50: row 3, column 7.
    @(negedge clk);
    set_cnt(323, 80);
    @(posedge clk);
    #1;
    check("b rom_addr row3", 32'(ifb.rom_addr), 3);
    @(posedge clk);
    #1;
    check("b col7 fg", 32'(ifb.rgb), 7);
    check("a outside bg", 32'(ifa.rgb), 1);
    pixel(324, 80);
    check("b right edge bg", 32'(ifb.rgb), 1);
    check("b rom_addr hold", 32'(ifb.rom_addr), 3);

    pixel(100, 27);
    check("hblank a", 32'(ifa.rgb), 0);
    check("hblank b", 32'(ifb.rgb), 0);
    pixel(5, 627);
    check("no tick c1!=0", 32'(ifa.frame_tick), 0);

    // First tick checked cycle by cycle.
    @(negedge clk);
    set_cnt(0, 627);
    @(negedge clk);
    set_cnt(1, 627);
    check("tick pulse", 32'(ifa.frame_tick), 1);
    check_pos("t1", 1, 1, 1, 1);
    @(negedge clk);
    check("tick one clk", 32'(ifa.frame_tick), 0);

    do_ticks(6);
    check("t7 frame", 32'(u_a.frame_idx_q), 0);
    do_ticks(1);
    check("t8 frame", 32'(u_a.frame_idx_q), 1);
    do_ticks(23);
    check("t31 frame", 32'(u_a.frame_idx_q), 3);
    do_ticks(1);
    check("t32 frame wrap", 32'(u_a.frame_idx_q), 0);
    check_pos("t32", 32, 1, 32, 1);

    set_move(1'b0);
    pulses = 0;
    do_ticks(5);
    check("hold pulses", 32'(pulses), 5);
    check_pos("hold", 32, 1, 32, 1);
    check("hold frame", 32'(u_a.frame_idx_q), 0);
    check("hold anim", 32'(u_a.anim_cnt_q), 0);
    set_move(1'b1);

    do_ticks(552);
    check_pos("t584", 584, 1, 584, 1);
    do_ticks(1);
    check_pos("t585 ybounce", 585, 1, 583, 0);
    do_ticks(207);
    check_pos("t792", 792, 1, 376, 0);
    do_ticks(1);
    check_pos("t793 xbounce", 791, 0, 375, 0);
    do_ticks(375);
    check_pos("t1168", 416, 0, 0, 0);
    do_ticks(1);
    check_pos("t1169 ytop", 415, 0, 1, 1);
    do_ticks(415);
    check_pos("t1584", 0, 0, 416, 1);
    do_ticks(1);
    check_pos("t1585 xleft", 1, 1, 417, 1);

    // Mid-line asynchronous reset.
    pixel(216, 27);
    check("pre-reset bg", 32'(ifa.rgb), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rgb", 32'(ifa.rgb), 0);
    check("async rom_addr", 32'(ifa.rom_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_pos("post-reset", 0, 1, 0, 1);
    check("post-reset frame", 32'(u_a.frame_idx_q), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("resume fg", 32'(ifa.rgb), 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
